// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: the MDU state encoding and the register-0 constant,
// which the forwarding logic also uses.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero never carries a real dependency, so it never matches.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: IDLE -> BUSY (countdown) -> DONE -> IDLE.
module mdu_busy_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  mdu_state_t       r_state;
  mdu_state_t       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // The start edge and the DONE cycle each take one slot, so the countdown
  // begins at N-2 to give an occupancy of exactly N cycles.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      MDU_IDLE: begin
        if (i_start) begin
          w_count_next = i_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MULT_CYCLES - 2);
          w_state_next = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (r_count == '0) begin
          w_state_next = MDU_DONE;
        end else begin
          w_count_next = r_count - CNT_W'(1);
        end
      end
      MDU_DONE: begin
        w_state_next = MDU_IDLE;
      end
      default: begin
        w_state_next = MDU_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != MDU_IDLE);
  assign o_done = (r_state == MDU_DONE);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush generation for hazards that bypassing cannot cover: load-use,
// ID-resolved branch/jr operands, and accesses to a busy mult/div unit.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        WriteRegE,
  input  logic [4:0]        WriteRegM,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpRegD,
  input  logic              PCSrcD,
  input  logic              MduReadD,
  input  logic              MduWriteD,
  input  logic              MduStartE,
  input  logic              MduIsDivE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              FlushD,
  output logic              MduBusy,
  output logic              MduDone,
  output logic [PERF_W-1:0] StallCount
);

  logic              w_lwstall;
  logic              w_branch_dep_e;
  logic              w_branch_dep_m;
  logic              w_branchstall;
  logic              w_mdustall;
  logic              w_stall;
  logic              w_mdu_busy;
  logic              w_mdu_done;
  logic [PERF_W-1:0] r_stall_count;

  mdu_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_busy_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (MduStartE),
    .i_is_div(MduIsDivE),
    .o_busy  (w_mdu_busy),
    .o_done  (w_mdu_done)
  );

  assign w_lwstall = RegWriteE & MemtoRegE &
                     (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD));

  // jr/jalr only reads rs; beq/bne compares both operands.
  assign w_branch_dep_e = RegWriteE &
                          (reg_match(WriteRegE, RsD) | (BranchD & reg_match(WriteRegE, RtD)));
  assign w_branch_dep_m = MemtoRegM &
                          (reg_match(WriteRegM, RsD) | (BranchD & reg_match(WriteRegM, RtD)));
  assign w_branchstall  = (BranchD | JumpRegD) & (w_branch_dep_e | w_branch_dep_m);

  assign w_mdustall = (MduReadD | MduWriteD) & (w_mdu_busy | MduStartE);

  assign w_stall = rst_n & (w_lwstall | w_branchstall | w_mdustall);

  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushE  = w_stall;
  // A stalled branch re-resolves next cycle, so it must not flush yet.
  assign FlushD  = rst_n & PCSrcD & ~w_stall;
  assign MduBusy = w_mdu_busy;
  assign MduDone = w_mdu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + PERF_W'(1);
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a second instance with a 4-bit perf
// counter shares the stimulus to exercise saturation.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  RsD, RtD, WriteRegE, WriteRegM;
  logic        RegWriteE, MemtoRegE, MemtoRegM, BranchD, JumpRegD, PCSrcD;
  logic        MduReadD, MduWriteD, MduStartE, MduIsDivE;
  logic        StallF, StallD, FlushE, FlushD, MduBusy, MduDone;
  logic [31:0] StallCount;
  logic        StallF_b, StallD_b, FlushE_b, FlushD_b, MduBusy_b, MduDone_b;
  logic [3:0]  StallCount_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_unit u_dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD), .PCSrcD(PCSrcD),
    .MduReadD(MduReadD), .MduWriteD(MduWriteD), .MduStartE(MduStartE), .MduIsDivE(MduIsDivE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .MduBusy(MduBusy), .MduDone(MduDone), .StallCount(StallCount)
  );

  hazard_stall_unit #(.PERF_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD), .PCSrcD(PCSrcD),
    .MduReadD(MduReadD), .MduWriteD(MduWriteD), .MduStartE(MduStartE), .MduIsDivE(MduIsDivE),
    .StallF(StallF_b), .StallD(StallD_b), .FlushE(FlushE_b), .FlushD(FlushD_b),
    .MduBusy(MduBusy_b), .MduDone(MduDone_b), .StallCount(StallCount_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    RsD = 5'd0; RtD = 5'd0; WriteRegE = 5'd0; WriteRegM = 5'd0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; JumpRegD = 1'b0; PCSrcD = 1'b0;
    MduReadD = 1'b0; MduWriteD = 1'b0; MduStartE = 1'b0; MduIsDivE = 1'b0;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_StallF"}, 32'(StallF), 32'(exp));
    chk({tag, "_StallD"}, 32'(StallD), 32'(exp));
    chk({tag, "_FlushE"}, 32'(FlushE), 32'(exp));
  endtask

  // Stimulus must never issue to a busy MDU.
  always @(negedge clk) begin
    if (rst_n && MduStartE && MduBusy) chk("mdu_start_busy", 32'd1, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; PCSrcD = 1'b1;
    #1;
    chk_stall("rst_gate", 1'b0);
    chk("rst_FlushD", 32'(FlushD), 32'd0);
    chk("rst_MduBusy", 32'(MduBusy), 32'd0);
    chk("rst_MduDone", 32'(MduDone), 32'd0);
    chk("rst_StallCount", StallCount, 32'd0);
    step(); step();
    rst_n = 1'b1;
    clr();
    #1;
    chk_stall("idle", 1'b0);

    // load-use on rs, then on rt
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    #1; chk_stall("lw_rs", 1'b1);
    step();
    WriteRegE = 5'd0; RsD = 5'd0;
    #1; chk_stall("lw_zero", 1'b0);
    WriteRegE = 5'd8; RtD = 5'd8;
    #1; chk_stall("lw_rt", 1'b1);
    step();
    clr();
    #1; chk("cnt_after_lw", StallCount, 32'd2);

    // branch behind ALU op; jr ignores rt
    BranchD = 1'b1; RtD = 5'd9; WriteRegE = 5'd9; RegWriteE = 1'b1;
    #1; chk_stall("br_alu_rt", 1'b1);
    step();
    BranchD = 1'b0; JumpRegD = 1'b1;
    #1; chk_stall("jr_rt", 1'b0);
    RsD = 5'd9;
    #1; chk_stall("jr_rs", 1'b1);
    step();
    clr();

    // branch two behind a load, with taken branch
    MemtoRegM = 1'b1; WriteRegM = 5'd4; BranchD = 1'b1; RsD = 5'd4; PCSrcD = 1'b1;
    #1; chk_stall("br_ldm", 1'b1);
    chk("br_ldm_FlushD", 32'(FlushD), 32'd0);
    step();
    MemtoRegM = 1'b0;
    #1; chk_stall("br_resolved", 1'b0);
    chk("br_resolved_FlushD", 32'(FlushD), 32'd1);
    chk("cnt_after_br", StallCount, 32'd5);
    step();
    clr();

    // lw and branch hazards together count once
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7; BranchD = 1'b1;
    #1; chk_stall("lw_br", 1'b1);
    step();
    clr();
    #1; chk("cnt_lw_br", StallCount, 32'd6);

    // mult then mflo
    MduStartE = 1'b1; MduReadD = 1'b1;
    #1; chk_stall("mul_c0", 1'b1);
    chk("mul_c0_busy", 32'(MduBusy), 32'd0);
    step();
    MduStartE = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mul_c%0d_busy", c), 32'(MduBusy), 32'd1);
      chk($sformatf("mul_c%0d_done", c), 32'(MduDone), 32'(c == 4));
      chk_stall($sformatf("mul_c%0d", c), 1'b1);
      step();
    end
    #1;
    chk("mul_c5_busy", 32'(MduBusy), 32'd0);
    chk("mul_c5_done", 32'(MduDone), 32'd0);
    chk_stall("mul_c5", 1'b0);
    chk("cnt_mul", StallCount, 32'd11);
    clr();

    // full divide
    MduStartE = 1'b1; MduIsDivE = 1'b1;
    #1; step();
    MduStartE = 1'b0; MduIsDivE = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      #1;
      chk($sformatf("div_c%0d_busy", c), 32'(MduBusy), 32'd1);
      chk($sformatf("div_c%0d_done", c), 32'(MduDone), 32'(c == 32));
      step();
    end
    #1;
    chk("div_c33_busy", 32'(MduBusy), 32'd0);
    chk("cnt_div", StallCount, 32'd11);
    chk("cnt_b_div", 32'(StallCount_b), 32'd11);

    // divide aborted by reset at cycle 10
    MduStartE = 1'b1; MduIsDivE = 1'b1;
    #1; step();
    MduStartE = 1'b0; MduIsDivE = 1'b0;
    for (int c = 1; c <= 9; c++) step();
    MduReadD = 1'b1; PCSrcD = 1'b1;
    #1;
    chk_stall("divrst_c10", 1'b1);
    chk("divrst_c10_busy", 32'(MduBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_stall("divrst_in", 1'b0);
    chk("divrst_in_FlushD", 32'(FlushD), 32'd0);
    chk("divrst_in_busy", 32'(MduBusy), 32'd0);
    chk("divrst_in_done", 32'(MduDone), 32'd0);
    chk("divrst_in_cnt", StallCount, 32'd0);
    chk("divrst_in_cnt_b", 32'(StallCount_b), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("divrst_out_busy", 32'(MduBusy), 32'd0);
    chk_stall("divrst_out", 1'b0);
    chk("divrst_out_FlushD", 32'(FlushD), 32'd1);
    chk("divrst_out_cnt", StallCount, 32'd0);
    clr();

    // perf counter saturation on the 4-bit instance
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat_i%0d", i), 32'(StallCount_b), (i < 15) ? 32'(i) : 32'd15);
    end
    chk("sat_wide_cnt", StallCount, 32'd20);
    clr();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Generates pipeline stall and flush controls for the 5-stage MIPS pipeline: StallF, StallD, FlushE and FlushD.
- Sits beside the forwarding logic. It covers the hazards that bypassing cannot resolve:
  - load-use;
  - branch/jr operands resolved in ID;
  - reads or new issues against a busy multi-cycle mult/div unit (MDU).
- Contains the MDU busy FSM/counter and a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, EX-side cycles a mult/multu occupies the MDU (>=2)
DIV_CYCLES, 32, cycles a div/divu occupies the MDU (>=2, > MULT_CYCLES)
CNT_W, 6, MDU countdown width; must hold DIV_CYCLES-1
PERF_W, 32, stall-cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsD  in  5  ID source register 1
RtD  in  5  ID source register 2
WriteRegE  in  5  EX destination register
WriteRegM  in  5  MEM destination register
RegWriteE  in  1  EX instruction writes the register file
MemtoRegE  in  1  EX instruction is a load
MemtoRegM  in  1  MEM instruction is a load
BranchD  in  1  ID is beq/bne (compares RsD and RtD)
JumpRegD  in  1  ID is jr/jalr (uses RsD only)
PCSrcD  in  1  branch/jump taken, resolved in ID
MduReadD  in  1  ID is mfhi/mflo
MduWriteD  in  1  ID is mult/div/mthi/mtlo
MduStartE  in  1  MDU op issuing from EX this cycle
MduIsDivE  in  1  qualifies MduStartE: 1 = divide
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushE  out  1  insert bubble into ID/EX
FlushD  out  1  clear IF/ID register (taken branch)
MduBusy  out  1  MDU FSM not IDLE
MduDone  out  1  HI/LO commit cycle
StallCount  out  PERF_W  saturating count of StallD cycles

Behaviour:
Reset (rst_n low, asynchronous)
- FSM = IDLE, countdown = 0, StallCount = 0.
- All outputs 0 while rst_n is low. Combinational outputs are gated by rst_n.

Stall sources (combinational)
- Register match: a register r "matches" when r != 0 and r equals RsD, or r equals RtD for the RtD-using instructions below.
- lwstall = RegWriteE & MemtoRegE & (WriteRegE matches RsD or RtD).
- branchstall = (BranchD | JumpRegD) and either:
  - RegWriteE & WriteRegE matches; or
  - MemtoRegM & WriteRegM matches.
  - JumpRegD compares RsD only. BranchD compares RsD and RtD.
- mdustall = (MduReadD | MduWriteD) & (state != IDLE | MduStartE).
- stall = lwstall | branchstall | mdustall.

Output equations
- StallF = StallD = FlushE = stall.
- FlushD = PCSrcD & ~stall. A stalled branch must not flush.

MDU FSM states: IDLE, BUSY, DONE
- IDLE:
  - MduStartE: load countdown with DIV_CYCLES-2 if MduIsDivE, else MULT_CYCLES-2, then go to BUSY.
  - No MduStartE: stay in IDLE.
- BUSY:
  - countdown == 0: go to DONE.
  - Otherwise decrement.
- DONE:
  - MduDone = 1 for exactly one cycle; HI/LO commit at this edge.
  - Always returns to IDLE.
- Total occupancy, from the MduStartE edge to IDLE, is exactly N cycles (MULT_CYCLES or DIV_CYCLES).
- MduStartE while not IDLE is illegal, because mdustall prevents it. It is ignored; the bench asserts it never occurs.
- MduBusy = (state != IDLE), registered.

Performance counter
- StallCount increments on every clock edge where stall = 1.
- Saturates at all-ones; no wrap.

Simultaneous events
- lwstall and branchstall on the same cycle: a single stall. The branch re-evaluates the next cycle and then forwards via ForwardAD/BD.
- mdustall during DONE: still stalls. The mfhi/mflo issues on the cycle after commit.
- Reset mid-BUSY: aborts the op; the FSM returns to IDLE.

Decomposition:
- Shared package (pipeline pkg): MDU state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and REG_ZERO=5'd0. The same register-0 constant is used by the forwarding logic.
- One sub-module: mdu_busy_tracker, containing the FSM, countdown, MduBusy and MduDone.
- Stall equations and the perf counter stay in the top.

Test Plan:
1. Load-use: WriteRegE=5'd8, MemtoRegE=1, RegWriteE=1, RsD=5'd8 -> StallF=StallD=FlushE=1 for 1 cycle. With WriteRegE=0 and RsD=0 -> no stall.
2. Branch after ALU op: BranchD=1, RtD=5'd9, WriteRegE=9, RegWriteE=1, MemtoRegE=0 -> stall = 1. Same case with JumpRegD only and RtD match -> no stall.
3. Branch two cycles behind a load: MemtoRegM=1, WriteRegM=5'd4, BranchD=1, RsD=4 -> stall. PCSrcD=1 on the same cycle -> FlushD=0. Next cycle, with stall clear -> FlushD=1.
4. Mult then mflo: MduStartE=1, MduIsDivE=0 at cycle 0 -> MduBusy=1 for cycles 1..4, MduDone=1 in cycle 4. MduReadD held from cycle 0 -> stall for cycles 0..4, released in cycle 5.
5. Div with reset: MduIsDivE=1 -> MduBusy high for 32 cycles. Assert rst_n=0 at cycle 10 -> all outputs 0 immediately. After release, state is IDLE and StallCount is 0.
6. Perf counter saturation: with PERF_W=4, hold a stall source for 20 cycles -> StallCount reaches 15 and stays at 15.
